spgd_pert_sequencer: RTL and testbench
======================================

# spgd_pert_sequencer

Two-sided perturbation sequencer for the SPGD loop. Each iteration it snapshots the free-running perturbation pair from the PRNG (PERT_A/PERT_B = RNG × SIGMA). It drives the actuators to u+δ, waits for settling and a metric sample, then drives u−δ, waits for settling and a second sample. It then emits ΔJ = J+ − J− together with the δ snapshot to the gradient-update stage. It sits between the PRNG and the actuator DAC/update path, and is the only block that decides when perturbations are applied.

## Interface
- FP_WIDTH, 64: fixed-point word width, two's complement, Q(INT_WIDTH).(FP_WIDTH−INT_WIDTH).
- INT_WIDTH, 16: integer bits including sign.
- SETTLE_W, 16: width of the settle-count input and internal counter.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins one iteration when idle.
- abort  in  1  pulse; cancels the iteration in progress.
- settle_cycles  in  SETTLE_W  settle wait after each actuator change.
- u_a, u_b  in  FP_WIDTH each  nominal actuator commands.
- pert_a, pert_b  in  FP_WIDTH each  PRNG perturbations (PERT_A/PERT_B).
- metric_in  in  FP_WIDTH  metric sample J.
- metric_valid  in  1  metric_in is valid this cycle.
- act_a, act_b  out  FP_WIDTH each  registered actuator drive.
- phase  out  2  0 = nominal, 1 = positive, 2 = negative.
- meas_req  out  1  high while waiting for a metric sample.
- busy  out  1  high whenever state ≠ IDLE.
- update_valid  out  1  one-cycle result strobe.
- delta_j  out  FP_WIDTH  J+ − J−.
- pert_a_q, pert_b_q  out  FP_WIDTH each  latched δ for this iteration.
- iter_count  out  32  number of completed iterations.

## Operation
- States: IDLE, POS_SETTLE, POS_MEAS, NEG_SETTLE, NEG_MEAS.
- IDLE + start: latch pert_a/pert_b into pert_*_q, load counter with settle_cycles, go to POS_SETTLE.
- Start while busy is ignored.
- *_SETTLE: if counter == 0 go to *_MEAS, else decrement.
- POS_MEAS + metric_valid: capture J+, reload counter, go to NEG_SETTLE.
- NEG_MEAS + metric_valid: capture J−, compute delta_j, pulse update_valid, increment iter_count (wraps at 2^32), go to IDLE.
- metric_valid outside *_MEAS is ignored. The sample is taken on the first valid cycle only.
- Actuator drive, registered every cycle from the current u and the latched δ:
  - IDLE: act = u.
  - POS_*: act = u + pert_q.
  - NEG_*: act = u − pert_q.
- phase follows the same mapping. meas_req = state ∈ {POS_MEAS, NEG_MEAS}.
- Arithmetic: add/subtract at FP_WIDTH+1 bits, then reduce to FP_WIDTH bits per the Configuration section. No rescaling; the binary point is preserved.
- abort has priority over every other event, including a simultaneous metric_valid. On abort:
  - next state is IDLE and act returns to u;
  - no update_valid pulse; iter_count, delta_j and pert_*_q are unchanged.
- Reset mid-iteration behaves like abort but also clears all registers.

## Timing
- Reset values: all outputs 0, state IDLE. act_a/act_b stay 0 until the first clock after reset release, then follow u.
- E0 is the edge that samples start. Let S = settle_cycles.
  - act = u+δ and phase = 1 are visible after E0.
  - POS_MEAS is entered after E(S+1).
  - With metric_valid already high, J+ is captured at E(S+2) and act = u−δ is visible after it.
  - J− is captured at E(2S+4). update_valid, delta_j and act = u are visible after that edge.
- Minimum iteration time: S = 0 with metric_valid held high gives update_valid high for the cycle after E4, and busy high for 4 cycles.
- delta_j and pert_*_q hold until the next completed iteration.
- start is accepted in the cycle immediately after update_valid.

## Configuration
- SPGD_SEQ_SAT_EN defined: act and delta_j saturate to the most positive value (0x7FF…F) or the most negative value (0x800…0) on overflow.
- Not defined: the result is truncated to FP_WIDTH bits (two's-complement wrap).

## Structure
- Shared package spgd_pkg:
  - state enum spgd_seq_state_t;
  - phase encodings PH_NOM, PH_POS, PH_NEG;
  - the Q-format constants FP_WIDTH and INT_WIDTH.
- One sub-module, spgd_sat_addsub: a combinational FP_WIDTH add/subtract with optional saturation, controlled by SPGD_SEQ_SAT_EN.
- It is instantiated three times: act_a, act_b and delta_j.

## Test plan
1. Reset asserted mid-POS_SETTLE → all outputs 0 and state IDLE immediately (asynchronous). After release, act_a = u_a on the next edge.
2. u_a = 1.0 (0x0001_0000_0000_0000), pert_a = 0.25, S = 3, metric_valid delayed, J+ = 2.0, J− = 1.5 → act_a = 1.25 then 0.75 then 1.0; delta_j = 0.5; update_valid pulses once; iter_count = 1.
3. S = 0, metric_valid held high → update_valid exactly 4 cycles after start. A back-to-back start the following cycle yields iter_count = 2.
4. abort on the same cycle as metric_valid in NEG_MEAS → no update_valid; delta_j and iter_count unchanged; act = u next cycle.
5. start pulsed during NEG_SETTLE, and metric_valid pulsed during POS_SETTLE → both ignored; the sequence completes normally.
6. u_a = 0x7FFF_0000_0000_0000, pert_a = +1.0 → with SPGD_SEQ_SAT_EN, act_a = 0x7FFF_FFFF_FFFF_FFFF; without it, act_a = 0x8000_0000_0000_0000.

Source files
------------

// File: rtl/spgd_pkg.sv
// spgd_pkg: types and constants shared by the SPGD perturbation sequencer.
// Holds the sequencer state enum, the phase encodings and the Q-format widths.
// No logic lives here beyond a small state-to-phase helper.
package spgd_pkg;

  localparam int FP_WIDTH  = 64;  // fixed-point word width
  localparam int INT_WIDTH = 16;  // integer bits including sign

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_POS_SETTLE = 3'd1,
    ST_POS_MEAS   = 3'd2,
    ST_NEG_SETTLE = 3'd3,
    ST_NEG_MEAS   = 3'd4
  } spgd_seq_state_t;

  localparam logic [1:0] PH_NOM = 2'd0;
  localparam logic [1:0] PH_POS = 2'd1;
  localparam logic [1:0] PH_NEG = 2'd2;

  function automatic logic [1:0] phase_of(input spgd_seq_state_t s);
    logic [1:0] p;
    p = PH_NOM;
    if (s == ST_POS_SETTLE || s == ST_POS_MEAS) p = PH_POS;
    if (s == ST_NEG_SETTLE || s == ST_NEG_MEAS) p = PH_NEG;
    return p;
  endfunction

endpackage

// File: rtl/spgd_sat_addsub.sv
// spgd_sat_addsub: combinational two's-complement add/subtract, y = a +/- b.
// Latency: zero cycles. No flow control (pure combinational).
// Ports: a, b operands; sub selects a-b; y result.
// Macro SPGD_SEQ_SAT_EN: when defined the result saturates to the most
// positive / most negative value on overflow, otherwise it wraps.
module spgd_sat_addsub #(
  parameter int W = spgd_pkg::FP_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

`ifdef SPGD_SEQ_SAT_EN
  logic [W:0] a_x;
  logic [W:0] b_x;
  logic [W:0] s_x;

  // One guard bit: the sum fits in W+1 bits, so overflow shows up as the
  // two top bits disagreeing; the guard bit then holds the true sign.
  assign a_x = {a[W-1], a};
  assign b_x = {b[W-1], b};
  assign s_x = sub ? (a_x - b_x) : (a_x + b_x);

  always_comb begin
    y = s_x[W-1:0];
    if (s_x[W] != s_x[W-1]) begin
      y = s_x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  // Wrapping mode keeps only the low W bits of the W+1-bit result.
  assign y = sub ? (a - b) : (a + b);
`endif

endmodule

// File: rtl/spgd_pert_sequencer.sv
// spgd_pert_sequencer: two-sided SPGD perturbation sequencer (u+d, settle,
// sample J+, u-d, settle, sample J-, emit dJ = J+ - J- with the d snapshot).
// Latency: update_valid after edge 2S+4 from the start edge (S = settle_cycles)
// when samples are immediately valid. Backpressure: none; start is ignored
// while busy, abort cancels at any time and wins over a concurrent sample.
// Ports: clk/rst (async active-low); start, abort, settle_cycles control;
// u_a/u_b nominal commands; pert_a/pert_b PRNG perturbations; metric_in /
// metric_valid sample; act_a/act_b registered drive; phase, meas_req, busy
// status; update_valid, delta_j, pert_a_q, pert_b_q result; iter_count.
// Macro SPGD_SEQ_SAT_EN selects saturating (defined) or wrapping arithmetic.
module spgd_pert_sequencer #(
  parameter int FP_WIDTH = spgd_pkg::FP_WIDTH,
  parameter int SETTLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [FP_WIDTH-1:0] u_a,
  input  logic [FP_WIDTH-1:0] u_b,
  input  logic [FP_WIDTH-1:0] pert_a,
  input  logic [FP_WIDTH-1:0] pert_b,
  input  logic [FP_WIDTH-1:0] metric_in,
  input  logic                metric_valid,
  output logic [FP_WIDTH-1:0] act_a,
  output logic [FP_WIDTH-1:0] act_b,
  output logic [1:0]          phase,
  output logic                meas_req,
  output logic                busy,
  output logic                update_valid,
  output logic [FP_WIDTH-1:0] delta_j,
  output logic [FP_WIDTH-1:0] pert_a_q,
  output logic [FP_WIDTH-1:0] pert_b_q,
  output logic [31:0]         iter_count
);

  import spgd_pkg::*;

  localparam logic [SETTLE_W-1:0] CNT_ONE = {{(SETTLE_W-1){1'b0}}, 1'b1};

  spgd_seq_state_t     state;
  spgd_seq_state_t     state_nx;
  logic [SETTLE_W-1:0] cnt;
  logic [FP_WIDTH-1:0] j_pos;

  logic                start_ok;
  logic                cap_pos;
  logic                cap_neg;
  logic                in_settle;
  logic [FP_WIDTH-1:0] pa_nx;
  logic [FP_WIDTH-1:0] pb_nx;
  logic [FP_WIDTH-1:0] drv_a;
  logic [FP_WIDTH-1:0] drv_b;
  logic                drv_sub;
  logic [FP_WIDTH-1:0] act_a_nx;
  logic [FP_WIDTH-1:0] act_b_nx;
  logic [FP_WIDTH-1:0] dj_nx;

  assign start_ok  = (state == ST_IDLE) && start && !abort;
  assign cap_pos   = (state == ST_POS_MEAS) && metric_valid && !abort;
  assign cap_neg   = (state == ST_NEG_MEAS) && metric_valid && !abort;
  assign in_settle = (state == ST_POS_SETTLE) || (state == ST_NEG_SETTLE);

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       if (start)        state_nx = ST_POS_SETTLE;
        ST_POS_SETTLE: if (cnt == '0)    state_nx = ST_POS_MEAS;
        ST_POS_MEAS:   if (metric_valid) state_nx = ST_NEG_SETTLE;
        ST_NEG_SETTLE: if (cnt == '0)    state_nx = ST_NEG_MEAS;
        ST_NEG_MEAS:   if (metric_valid) state_nx = ST_IDLE;
        default:                         state_nx = ST_IDLE;
      endcase
    end
  end

  // The drive register is loaded from the *next* state and the *next* delta
  // so that u+d is already on the actuators right after the start edge.
  assign pa_nx   = start_ok ? pert_a : pert_a_q;
  assign pb_nx   = start_ok ? pert_b : pert_b_q;
  assign drv_a   = (state_nx == ST_IDLE) ? '0 : pa_nx;
  assign drv_b   = (state_nx == ST_IDLE) ? '0 : pb_nx;
  assign drv_sub = (state_nx == ST_NEG_SETTLE) || (state_nx == ST_NEG_MEAS);

  spgd_sat_addsub #(.W(FP_WIDTH)) u_act_a (
    .a(u_a), .b(drv_a), .sub(drv_sub), .y(act_a_nx)
  );

  spgd_sat_addsub #(.W(FP_WIDTH)) u_act_b (
    .a(u_b), .b(drv_b), .sub(drv_sub), .y(act_b_nx)
  );

  spgd_sat_addsub #(.W(FP_WIDTH)) u_delta_j (
    .a(j_pos), .b(metric_in), .sub(1'b1), .y(dj_nx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      j_pos        <= '0;
      act_a        <= '0;
      act_b        <= '0;
      update_valid <= 1'b0;
      delta_j      <= '0;
      pert_a_q     <= '0;
      pert_b_q     <= '0;
      iter_count   <= '0;
    end else begin
      state        <= state_nx;
      act_a        <= act_a_nx;
      act_b        <= act_b_nx;
      update_valid <= cap_neg;

      if (in_settle && cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
      if (start_ok) begin
        pert_a_q <= pert_a;
        pert_b_q <= pert_b;
        cnt      <= settle_cycles;
      end
      if (cap_pos) begin
        j_pos <= metric_in;
        cnt   <= settle_cycles;
      end
      if (cap_neg) begin
        delta_j    <= dj_nx;
        iter_count <= iter_count + 32'd1;
      end
    end
  end

  assign phase    = phase_of(state);
  assign meas_req = (state == ST_POS_MEAS) || (state == ST_NEG_MEAS);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_spgd_pert_sequencer.sv
// Testbench for spgd_pert_sequencer: randomized iterations checked against a
// plain-arithmetic reference, with completed results queued on a scoreboard
// and compared by a separate monitor whenever update_valid is seen.
module tb_spgd_pert_sequencer;

  localparam int W  = 64;
  localparam int SW = 16;
  localparam logic signed [65:0] MAXV = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] MINV = -66'sh0_8000_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] settle_cycles = '0;
  logic [W-1:0]  u_a = '0, u_b = '0, pert_a = '0, pert_b = '0, metric_in = '0;
  logic          metric_valid = 1'b0;
  logic [W-1:0]  act_a, act_b, delta_j, pert_a_q, pert_b_q;
  logic [1:0]    phase;
  logic          meas_req, busy, update_valid;
  logic [31:0]   iter_count;

  always #5 clk = ~clk;

  spgd_pert_sequencer #(.FP_WIDTH(W), .SETTLE_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .settle_cycles(settle_cycles), .u_a(u_a), .u_b(u_b),
    .pert_a(pert_a), .pert_b(pert_b), .metric_in(metric_in),
    .metric_valid(metric_valid), .act_a(act_a), .act_b(act_b),
    .phase(phase), .meas_req(meas_req), .busy(busy),
    .update_valid(update_valid), .delta_j(delta_j),
    .pert_a_q(pert_a_q), .pert_b_q(pert_b_q), .iter_count(iter_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] dj;
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    logic [31:0]  cnt;
  } exp_t;

  exp_t sb[$];

  // Reference state: what the last completed iteration left behind.
  logic [W-1:0] m_dj   = '0;
  logic [31:0]  m_iter = '0;

  // Reference add/sub: exact signed arithmetic, then clamp or wrap.
  function automatic logic [W-1:0] ref_as(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit sub);
    logic signed [65:0] r;
    r = sub ? ($signed(a) - $signed(b)) : ($signed(a) + $signed(b));
`ifdef SPGD_SEQ_SAT_EN
    if (r > MAXV) r = MAXV;
    if (r < MINV) r = MINV;
`endif
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for meas_req and checks how many edges it took.
  task automatic wait_meas(input int exp_edges, input string nm);
    int k;
    k = 0;
    while (meas_req !== 1'b1 && k < exp_edges + 40) begin
      tick();
      k++;
    end
    chk(nm, 64'(k), 64'(exp_edges));
  endtask

  // Scoreboard monitor: every update_valid cycle must match a queued result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b1 && update_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_update: got update_valid=1 expected no result pending");
      end else begin
        e = sb.pop_front();
        chk("sb_delta_j", delta_j, e.dj);
        chk("sb_pert_a_q", pert_a_q, e.pa);
        chk("sb_pert_b_q", pert_b_q, e.pb);
        chk("sb_iter_count", 64'(iter_count), 64'(e.cnt));
      end
    end
  end

  // One full iteration. dp/dn delay the samples; noise injects an ignored
  // early sample and an ignored restart; abort_neg kills it at the J- sample.
  task automatic do_iter(input int s, input int dp, input int dn,
                         input logic [W-1:0] ua, input logic [W-1:0] ub,
                         input logic [W-1:0] pa, input logic [W-1:0] pb,
                         input logic [W-1:0] jp, input logic [W-1:0] jn,
                         input bit abort_neg, input bit noise);
    exp_t e;
    int used;
    u_a = ua; u_b = ub; pert_a = pa; pert_b = pb;
    settle_cycles = SW'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
    pert_a = rnd64();
    pert_b = rnd64();
    chk("act_a_pos", act_a, ref_as(ua, pa, 1'b0));
    chk("act_b_pos", act_b, ref_as(ub, pb, 1'b0));
    chk("phase_pos", 64'(phase), 64'd1);
    chk("busy_pos", 64'(busy), 64'd1);
    used = 0;
    if (noise) begin
      metric_valid = 1'b1;
      metric_in = rnd64();
      tick();
      metric_valid = 1'b0;
      used = 1;
    end
    wait_meas(s + 1 - used, "pos_settle_len");
    repeat (dp) tick();
    metric_in = jp;
    metric_valid = 1'b1;
    tick();
    metric_valid = 1'b0;
    metric_in = rnd64();
    chk("act_a_neg", act_a, ref_as(ua, pa, 1'b1));
    chk("act_b_neg", act_b, ref_as(ub, pb, 1'b1));
    chk("phase_neg", 64'(phase), 64'd2);
    used = 0;
    if (noise) begin
      start = 1'b1;
      pert_a = rnd64();
      tick();
      start = 1'b0;
      used = 1;
    end
    wait_meas(s + 1 - used, "neg_settle_len");
    repeat (dn) tick();
    metric_in = jn;
    metric_valid = 1'b1;
    if (abort_neg) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      metric_valid = 1'b0;
      chk("abort_no_update", 64'(update_valid), 64'd0);
      chk("abort_delta_j", delta_j, m_dj);
      chk("abort_iter", 64'(iter_count), 64'(m_iter));
    end else begin
      m_iter++;
      m_dj = ref_as(jp, jn, 1'b1);
      e.dj = m_dj; e.pa = pa; e.pb = pb; e.cnt = m_iter;
      sb.push_back(e);
      tick();
      metric_valid = 1'b0;
      chk("done_phase", 64'(phase), 64'd0);
    end
    chk("done_act_a", act_a, ua);
    chk("done_act_b", act_b, ub);
    chk("done_busy", 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [W-1:0] ua, ub, pa, pb, jp, jn;

    // Reset state.
    u_a = 64'h0000_0003_0000_0000;
    #12;
    chk("rst_act_a", act_a, 64'd0);
    chk("rst_iter", 64'(iter_count), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_act_a", act_a, u_a);

    // Worked example: 1.0 +/- 0.25, S=3, delayed samples, 2.0 - 1.5 = 0.5.
    do_iter(3, 2, 3, 64'h0001_0000_0000_0000, 64'h0000_0000_0000_0000,
            64'h0000_4000_0000_0000, 64'h0000_4000_0000_0000,
            64'h0002_0000_0000_0000, 64'h0001_8000_0000_0000, 1'b0, 1'b0);
    tick();
    chk("ex_delta_j", delta_j, 64'h0000_8000_0000_0000);
    chk("ex_iter", 64'(iter_count), 64'd1);

    // Minimum iteration (S=0, metric_valid held) twice back to back.
    settle_cycles = '0;
    metric_valid = 1'b1;
    for (int it = 0; it < 2; it++) begin
      exp_t e;
      pa = rnd64(); pb = rnd64(); jp = rnd64(); jn = rnd64();
      pert_a = pa; pert_b = pb;
      m_iter++;
      m_dj = ref_as(jp, jn, 1'b1);
      e.dj = m_dj; e.pa = pa; e.pb = pb; e.cnt = m_iter;
      sb.push_back(e);
      start = 1'b1;
      metric_in = rnd64();
      tick();                       // E0
      start = 1'b0;
      chk("min_busy", 64'(busy), 64'd1);
      tick();                       // E1: enters POS_MEAS
      metric_in = jp;
      tick();                       // E2: J+ captured
      metric_in = rnd64();
      tick();                       // E3: enters NEG_MEAS
      chk("min_not_early", 64'(update_valid), 64'd0);
      metric_in = jn;
      tick();                       // E4: J- captured
      chk("min_update_at_4", 64'(update_valid), 64'd1);
      chk("min_idle_after", 64'(busy), 64'd0);
    end
    metric_valid = 1'b0;
    tick();
    chk("b2b_iter", 64'(iter_count), 64'(m_iter));

    // Abort at the J- sample, and ignored start/sample pulses.
    do_iter(2, 0, 0, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 1'b1, 1'b0);
    do_iter(2, 1, 0, rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, 1'b1);

    // Overflow of the positive drive, then abort from POS_SETTLE.
    u_a = 64'h7FFF_0000_0000_0000;
    pert_a = 64'h0001_0000_0000_0000;
    settle_cycles = SW'(4);
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef SPGD_SEQ_SAT_EN
    chk("ovf_act_a", act_a, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    chk("ovf_act_a", act_a, 64'h8000_0000_0000_0000);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ovf_abort_act", act_a, u_a);
    chk("ovf_abort_busy", 64'(busy), 64'd0);

    // Randomized iterations.
    for (int n = 0; n < 25; n++) begin
      ua = rnd64(); ub = rnd64(); pa = rnd64(); pb = rnd64();
      jp = rnd64(); jn = rnd64();
      do_iter(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), ua, ub, pa, pb, jp, jn,
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset in the middle of POS_SETTLE.
    u_a = 64'h0000_1234_0000_0000;
    settle_cycles = SW'(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_act_a", act_a, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_iter", 64'(iter_count), 64'd0);
    chk("arst_delta_j", delta_j, 64'd0);
    chk("arst_pert_a_q", pert_a_q, 64'd0);
    chk("arst_phase", 64'(phase), 64'd0);
    m_iter = '0;
    m_dj = '0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_hold_act", act_a, 64'd0);
    tick();
    chk("arst_follow_u", act_a, u_a);

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
